// File: rtl/board_pkg.sv
// Shared constants and types for the board randomizer: size/colour limits,
// LFSR polynomial and seed, and the fill FSM state encoding.
package board_pkg;

   localparam int          MAX_SIZE   = 26;
   localparam int          ADDR_W     = 10;
   localparam int          COLOR_W    = 3;
   localparam int          MIN_SIZE   = 2;
   localparam int          MIN_COLORS = 3;
   localparam int          MAX_COLORS = 8;
   localparam logic [15:0] LFSR_MASK  = 16'hB400;
   localparam logic [15:0] SEED       = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/board_rand_if.sv
// Request/ready handshake with the selection block plus the board memory
// write port. The selection block holds INITIALIZE_BOARD high until it sees
// BOARD_READY; BOARD_READY stays high until INITIALIZE_BOARD falls.
interface board_rand_if #(
   parameter int ADDR_W  = board_pkg::ADDR_W,
   parameter int COLOR_W = board_pkg::COLOR_W
);

   logic               INITIALIZE_BOARD;
   logic [4:0]         final_SIZE;
   logic [3:0]         final_COLOR_NUM;
   logic               BOARD_READY;
   logic               WR_EN;
   logic [ADDR_W-1:0]  WR_ADDR;
   logic [COLOR_W-1:0] WR_COLOR;

   modport master (
      output INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM,
      input  BOARD_READY, WR_EN, WR_ADDR, WR_COLOR
   );

   modport slave (
      input  INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM,
      output BOARD_READY, WR_EN, WR_ADDR, WR_COLOR
   );

endinterface

// File: rtl/board_rand_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset and
// never reaches zero from a non-zero seed.
module lfsr16 #(
   parameter logic [15:0] MASK = board_pkg::LFSR_MASK,
   parameter logic [15:0] SEED = board_pkg::SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 16'h0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/board_rand.sv
// Board randomizer: on request, clamps and latches board size/colour count,
// then writes one scaled pseudo-random colour per cell, one cell per clock.
module board_rand #(
   parameter int          MAX_SIZE = board_pkg::MAX_SIZE,
   parameter int          ADDR_W   = board_pkg::ADDR_W,
   parameter int          COLOR_W  = board_pkg::COLOR_W,
   parameter logic [15:0] SEED     = board_pkg::SEED
) (
   input  logic              MASTER_CLOCK,
   input  logic              RESET_N,
   board_rand_if.slave       bus,
   output board_pkg::state_t dbg_state,
   output logic [15:0]       dbg_lfsr
);

   import board_pkg::*;

   state_t             state_q, state_d;
   logic [4:0]         size_q, size_d;
   logic [3:0]         colors_q, colors_d;
   logic [ADDR_W:0]    n_q, n_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [COLOR_W-1:0] wr_color_q, wr_color_d;
   logic               ready_q, ready_d;

   logic [15:0]        lfsr;
   logic [4:0]         size_clamp;
   logic [3:0]         colors_clamp;
   logic [ADDR_W:0]    size_ext;
   logic [11:0]        prod;
   logic [COLOR_W-1:0] color_scaled;
   logic               last_cell;
   logic               unused_prod;

   lfsr16 #(.MASK(LFSR_MASK), .SEED(SEED)) u_lfsr (
      .clk    (MASTER_CLOCK),
      .rst_n  (RESET_N),
      .lfsr_o (lfsr)
   );

   // Clamp, scale and last-cell detection are pure datapath.
   always_comb begin
      size_clamp = bus.final_SIZE;
      if (bus.final_SIZE < 5'(MIN_SIZE))      size_clamp = 5'(MIN_SIZE);
      else if (bus.final_SIZE > 5'(MAX_SIZE)) size_clamp = 5'(MAX_SIZE);

      colors_clamp = bus.final_COLOR_NUM;
      if (bus.final_COLOR_NUM < 4'(MIN_COLORS))      colors_clamp = 4'(MIN_COLORS);
      else if (bus.final_COLOR_NUM > 4'(MAX_COLORS)) colors_clamp = 4'(MAX_COLORS);

      size_ext = (ADDR_W+1)'(size_q);
      // Scaling by multiply-and-shift keeps every cell to a single cycle and
      // always lands in 0..colors-1.
      prod         = {4'b0000, lfsr[7:0]} * {8'h00, colors_q};
      color_scaled = prod[8 +: COLOR_W];
      last_cell    = (({1'b0, wr_addr_q} + (ADDR_W+1)'(1)) == n_q);
   end

   assign unused_prod = ^prod;

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      colors_d   = colors_q;
      n_d        = n_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = '0;
      wr_color_d = '0;
      ready_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.INITIALIZE_BOARD) begin
               state_d  = LATCH;
               size_d   = size_clamp;
               colors_d = colors_clamp;
            end
         end
         LATCH: begin
            n_d        = size_ext * size_ext;
            state_d    = FILL;
            wr_en_d    = 1'b1;
            wr_color_d = color_scaled;
         end
         FILL: begin
            if (!bus.INITIALIZE_BOARD) begin
               state_d = IDLE;
            end else if (last_cell) begin
               state_d = DONE;
               ready_d = 1'b1;
            end else begin
               wr_en_d    = 1'b1;
               wr_addr_d  = wr_addr_q + ADDR_W'(1);
               wr_color_d = color_scaled;
            end
         end
         DONE: begin
            if (!bus.INITIALIZE_BOARD) state_d = IDLE;
            else                       ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         size_q     <= 5'(MIN_SIZE);
         colors_q   <= 4'(MIN_COLORS);
         n_q        <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_color_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         colors_q   <= colors_d;
         n_q        <= n_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_color_q <= wr_color_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.BOARD_READY = ready_q;
   assign bus.WR_EN       = wr_en_q;
   assign bus.WR_ADDR     = wr_addr_q;
   assign bus.WR_COLOR    = wr_color_q;
   assign dbg_state       = state_q;
   assign dbg_lfsr        = lfsr;

endmodule

// File: tb/tb_board_rand.sv
// Directed bench for board_rand: table of fill requests with hand-computed
// clamped sizes/colour counts, plus reset, abort and reset-mid-fill sequences.
module tb_board_rand;

   import board_pkg::*;

   logic        clk;
   logic        rst_n;
   state_t      dbg_state;
   logic [15:0] dbg_lfsr;

   board_rand_if bus ();

   board_rand dut (
      .MASTER_CLOCK (clk),
      .RESET_N      (rst_n),
      .bus          (bus),
      .dbg_state    (dbg_state),
      .dbg_lfsr     (dbg_lfsr)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference LFSR; lfsr_prev holds the value the DUT used at the last edge
   logic [15:0] lfsr_m, lfsr_prev;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_m    <= 16'hACE1;
         lfsr_prev <= 16'hACE1;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_color(input logic [15:0] l, input int c);
      int p;
      p = int'(l[7:0]) * c;
      return 3'(p >> 8);
   endfunction

   // driver tasks
   task automatic start_req(input logic [4:0] sz, input logic [3:0] col);
      @(negedge clk);
      bus.final_SIZE       = sz;
      bus.final_COLOR_NUM  = col;
      bus.INITIALIZE_BOARD = 1'b1;
      @(posedge clk); #1;
      chk("latch_state", 32'(dbg_state), 32'(LATCH));
      chk("latch_wr_en", 32'(bus.WR_EN), 32'd0);
   endtask

   task automatic check_writes(input int first, input int count, input int cl);
      for (int i = first; i < first + count; i++) begin
         @(posedge clk); #1;
         chk("wr_en", 32'(bus.WR_EN), 32'd1);
         chk("wr_addr", 32'(bus.WR_ADDR), 32'(i));
         chk("wr_color", 32'(bus.WR_COLOR), 32'(model_color(lfsr_prev, cl)));
         chk("color_range", 32'(int'(bus.WR_COLOR) < cl), 32'd1);
         chk("ready_low", 32'(bus.BOARD_READY), 32'd0);
      end
   endtask

   task automatic run_fill(input logic [4:0] sz, input logic [3:0] col,
                           input int n, input int cl, input bit wiggle);
      start_req(sz, col);
      if (wiggle) begin
         bus.final_SIZE      = 5'd3;
         bus.final_COLOR_NUM = 4'd5;
      end
      check_writes(0, n, cl);
      @(posedge clk); #1;
      chk("done_wr_en", 32'(bus.WR_EN), 32'd0);
      chk("done_ready", 32'(bus.BOARD_READY), 32'd1);
      chk("done_state", 32'(dbg_state), 32'(DONE));
      @(posedge clk); #1;
      chk("ready_hold", 32'(bus.BOARD_READY), 32'd1);
      @(negedge clk);
      bus.INITIALIZE_BOARD = 1'b0;
      @(posedge clk); #1;
      chk("ready_fall", 32'(bus.BOARD_READY), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'(IDLE));
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.BOARD_READY), 32'd0);
      chk({tag, "_wr_en"}, 32'(bus.WR_EN), 32'd0);
      chk({tag, "_wr_addr"}, 32'(bus.WR_ADDR), 32'd0);
      chk({tag, "_wr_color"}, 32'(bus.WR_COLOR), 32'd0);
      chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
      chk({tag, "_lfsr"}, 32'(dbg_lfsr), 32'hACE1);
   endtask

   typedef struct {
      logic [4:0] size;
      logic [3:0] colors;
      int         exp_n;
      int         exp_cl;
      bit         wiggle;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{size: 5'd2,  colors: 4'd3,  exp_n: 4,   exp_cl: 3, wiggle: 1'b0};
      vecs[1] = '{size: 5'd26, colors: 4'd8,  exp_n: 676, exp_cl: 8, wiggle: 1'b1};
      vecs[2] = '{size: 5'd0,  colors: 4'd15, exp_n: 4,   exp_cl: 8, wiggle: 1'b0};
      vecs[3] = '{size: 5'd31, colors: 4'd1,  exp_n: 676, exp_cl: 3, wiggle: 1'b0};
      vecs[4] = '{size: 5'd5,  colors: 4'd4,  exp_n: 25,  exp_cl: 4, wiggle: 1'b1};

      rst_n                = 1'b0;
      bus.INITIALIZE_BOARD = 1'b0;
      bus.final_SIZE       = 5'd0;
      bus.final_COLOR_NUM  = 4'd0;
      #23;
      check_outputs_zero("reset");

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("lfsr_seed", 32'(dbg_lfsr), 32'hACE1);
      @(posedge clk); #1;
      chk("lfsr_step1", 32'(dbg_lfsr), 32'hE270);
      @(posedge clk); #1;
      chk("lfsr_step2", 32'(dbg_lfsr), 32'h7138);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("lfsr_model", 32'(dbg_lfsr), 32'(lfsr_m));
      end

      for (int v = 0; v < 5; v++) begin
         run_fill(vecs[v].size, vecs[v].colors, vecs[v].exp_n, vecs[v].exp_cl, vecs[v].wiggle);
         repeat ($urandom_range(1, 4)) @(posedge clk);
      end

      // abort after write 50 of a 14x14 board
      start_req(5'd14, 4'd6);
      check_writes(0, 51, 6);
      @(negedge clk);
      bus.INITIALIZE_BOARD = 1'b0;
      @(posedge clk); #1;
      chk("abort_wr_en", 32'(bus.WR_EN), 32'd0);
      chk("abort_state", 32'(dbg_state), 32'(IDLE));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_ready", 32'(bus.BOARD_READY), 32'd0);
         chk("abort_idle_wr_en", 32'(bus.WR_EN), 32'd0);
      end
      run_fill(5'd2, 4'd3, 4, 3, 1'b0);

      // asynchronous reset in the middle of a 26x26 fill
      start_req(5'd26, 4'd7);
      check_writes(0, 101, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      bus.INITIALIZE_BOARD = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_lfsr", 32'(dbg_lfsr), 32'hE270);
      run_fill(5'd26, 4'd7, 676, 7, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
